// File: rtl/agc_fetch_if.sv
// Fetch-unit bus: memory read port toward the memory and the instruction/branch
// port toward the decoder. The master modport is the fetch unit.
interface agc_fetch_if;
  logic        mem_req;
  logic [11:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [14:0] mem_rdata;
  logic        instr_valid;
  logic [14:0] instr;
  logic [11:0] pc;
  logic        instr_ready;
  logic        br_taken;
  logic [11:0] br_target;
  logic        halt;
  logic        flush;

  modport master (
    output mem_req, mem_addr, instr_valid, instr, pc, flush,
    input  mem_gnt, mem_rvalid, mem_rdata, instr_ready, br_taken, br_target, halt
  );

  modport slave (
    input  mem_req, mem_addr, instr_valid, instr, pc, flush,
    output mem_gnt, mem_rvalid, mem_rdata, instr_ready, br_taken, br_target, halt
  );
endinterface

// File: rtl/agc_fetch.sv
// AGC instruction fetch: in-order reads, small instruction buffer, branch redirect.
// Define FETCH_PERF_EN to add saturating fetched/dropped/stall counters.
module agc_fetch #(
  parameter logic [11:0] ResetPc   = 12'o4000,
  parameter int unsigned FifoDepth = 2
) (
  input  logic        clock,
  input  logic        rst_l,
  agc_fetch_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0] perf_fetched_o,
  output logic [15:0] perf_dropped_o,
  output logic [15:0] perf_stall_o
`endif
);
  localparam int unsigned PtrW = $clog2(FifoDepth);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StBoot, StRun, StHalted} state_e;
  state_e state_q, state_d;

  logic [11:0]     fetch_pc_q, fetch_pc_d;
  logic [CntW-1:0] outst_q, outst_d, drop_q, drop_d, fcnt_q, fcnt_d;
  logic [PtrW-1:0] f_wr_q, f_wr_d, f_rd_q, f_rd_d, a_wr_q, a_wr_d, a_rd_q, a_rd_d;
  logic            flush_q;
  logic [26:0]     fifo_q [FifoDepth];
  logic [11:0]     aq_q   [FifoDepth];

  logic run, redirect, gnt_fire, rsp_ok, drop_word, push, pop, instr_valid;

  assign run         = (state_q == StRun);
  assign instr_valid = (fcnt_q != '0);
  assign bus.mem_req = run && !bus.halt &&
                       (({1'b0, outst_q} + {1'b0, fcnt_q}) < (CntW+1)'(FifoDepth));
  assign gnt_fire    = bus.mem_req && bus.mem_gnt;
  assign redirect    = run && !bus.halt && bus.br_taken;
  // A response with nothing outstanding is spurious and ignored entirely.
  assign rsp_ok      = bus.mem_rvalid && (outst_q != '0);
  assign drop_word   = rsp_ok && (drop_q != '0);
  assign push        = rsp_ok && (drop_q == '0) && !redirect;
  assign pop         = instr_valid && bus.instr_ready && !redirect;

  assign bus.mem_addr    = fetch_pc_q;
  assign bus.instr_valid = instr_valid;
  assign bus.instr       = instr_valid ? fifo_q[f_rd_q][14:0] : '0;
  assign bus.pc          = instr_valid ? fifo_q[f_rd_q][26:15] : '0;
  assign bus.flush       = flush_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StBoot:   state_d = StRun;
      StRun:    if (bus.halt) state_d = StHalted;
      StHalted: state_d = StHalted;
      default:  state_d = StBoot;
    endcase
  end

  always_comb begin
    outst_d    = outst_q + CntW'(gnt_fire) - CntW'(rsp_ok);
    // After a redirect every read still in flight is stale.
    drop_d     = redirect ? outst_d : drop_q - CntW'(drop_word);
    fetch_pc_d = fetch_pc_q;
    f_wr_d     = f_wr_q;
    f_rd_d     = f_rd_q;
    fcnt_d     = fcnt_q;
    a_wr_d     = a_wr_q;
    a_rd_d     = a_rd_q;
    if (redirect) begin
      fetch_pc_d = bus.br_target;
      f_wr_d     = '0;
      f_rd_d     = '0;
      fcnt_d     = '0;
      a_wr_d     = '0;
      a_rd_d     = '0;
    end else begin
      if (gnt_fire) fetch_pc_d = fetch_pc_q + 12'd1;
      if (push)     f_wr_d     = f_wr_q + PtrW'(1);
      if (pop)      f_rd_d     = f_rd_q + PtrW'(1);
      fcnt_d = fcnt_q + CntW'(push) - CntW'(pop);
      if (gnt_fire) a_wr_d     = a_wr_q + PtrW'(1);
      if (push)     a_rd_d     = a_rd_q + PtrW'(1);
    end
  end

  always_ff @(posedge clock or negedge rst_l) begin
    if (!rst_l) begin
      state_q    <= StBoot;
      fetch_pc_q <= ResetPc;
      outst_q    <= '0;
      drop_q     <= '0;
      fcnt_q     <= '0;
      f_wr_q     <= '0;
      f_rd_q     <= '0;
      a_wr_q     <= '0;
      a_rd_q     <= '0;
      flush_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      fcnt_q     <= fcnt_d;
      f_wr_q     <= f_wr_d;
      f_rd_q     <= f_rd_d;
      a_wr_q     <= a_wr_d;
      a_rd_q     <= a_rd_d;
      flush_q    <= redirect;
    end
  end

  // Storage needs no reset: outputs are masked while the buffer is empty.
  always_ff @(posedge clock) begin
    if (push)                  fifo_q[f_wr_q] <= {aq_q[a_rd_q], bus.mem_rdata};
    if (gnt_fire && !redirect) aq_q[a_wr_q]   <= fetch_pc_q;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clock) begin
    if (rst_l && bus.mem_rvalid && (outst_q == '0)) begin
      $error("agc_fetch: mem_rvalid with no outstanding read");
    end
  end
`endif

`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetched_q, perf_dropped_q, perf_stall_q;

  always_ff @(posedge clock or negedge rst_l) begin
    if (!rst_l) begin
      perf_fetched_q <= '0;
      perf_dropped_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (push && perf_fetched_q != 16'hFFFF) perf_fetched_q <= perf_fetched_q + 16'd1;
      if ((drop_word || (rsp_ok && redirect)) && perf_dropped_q != 16'hFFFF) begin
        perf_dropped_q <= perf_dropped_q + 16'd1;
      end
      if (instr_valid && !bus.instr_ready && perf_stall_q != 16'hFFFF) begin
        perf_stall_q <= perf_stall_q + 16'd1;
      end
    end
  end

  assign perf_fetched_o = perf_fetched_q;
  assign perf_dropped_o = perf_dropped_q;
  assign perf_stall_o   = perf_stall_q;
`endif
endmodule

// File: tb/tb_agc_fetch.sv
// Bench for agc_fetch: directed scenarios plus a random phase, checked against a
// transaction-level model (issue stream, in-flight read list, buffered-word list).
module tb_agc_fetch;
  localparam int Depth = 2;

  typedef struct {
    logic [11:0] addr;
    int          due;
    bit          stale;
  } rd_t;

  logic clock = 1'b0;
  logic rst_l = 1'b0;
  agc_fetch_if bus ();
`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetched, perf_dropped, perf_stall;
`endif

  agc_fetch #(.ResetPc(12'o4000), .FifoDepth(Depth)) dut (
    .clock (clock),
    .rst_l (rst_l),
    .bus   (bus)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched_o (perf_fetched),
    .perf_dropped_o (perf_dropped),
    .perf_stall_o   (perf_stall)
`endif
  );

  always #5 clock = ~clock;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lat_lo = 1, lat_hi = 1;
  int          m_fetched = 0, m_dropped = 0, m_stall = 0;
  bit          booting = 1'b1, halted = 1'b0, flush_exp = 1'b0;
  logic [11:0] issue_pc = 12'o4000;
  rd_t         mq[$];
  logic [11:0] mfifo[$];

  function automatic logic [14:0] mem_word(input logic [11:0] a);
    return 15'(32'(a) * 32'd13) ^ 15'h2A5A;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, compare at negedge+1, then advance the model.
  task automatic cycle(input bit gnt, input bit rdy, input bit br, input logic [11:0] tgt,
                       input bit hlt, input bit rv_ok);
    rd_t rsp;
    bit  rv, run, req, redir;
    int  inflight;
    rv       = rv_ok && mq.size() != 0 && mq[0].due <= cyc;
    inflight = mq.size();
    bus.mem_gnt     = gnt;
    bus.instr_ready = rdy;
    bus.br_taken    = br;
    bus.br_target   = tgt;
    bus.halt        = hlt;
    bus.mem_rvalid  = rv;
    if (rv) bus.mem_rdata = mem_word(mq[0].addr);
    else    bus.mem_rdata = 15'($urandom);
    #1;
    run = !booting && !halted;
    req = run && !hlt && (inflight + mfifo.size() < Depth);
    check("mem_req", 32'(bus.mem_req), 32'(req));
    check("instr_valid", 32'(bus.instr_valid), 32'(mfifo.size() != 0));
    if (mfifo.size() != 0) begin
      check("pc", 32'(bus.pc), 32'(mfifo[0]));
      check("instr", 32'(bus.instr), 32'(mem_word(mfifo[0])));
    end
    check("flush", 32'(bus.flush), 32'(flush_exp));
    if (req && gnt) check("mem_addr", 32'(bus.mem_addr), 32'(issue_pc));

    redir = run && !hlt && br;
    if (mfifo.size() != 0 && !rdy) m_stall++;
    if (mfifo.size() != 0 && rdy && !redir) void'(mfifo.pop_front());
    if (rv) begin
      rsp = mq.pop_front();
      if (rsp.stale || redir) m_dropped++;
      else begin
        mfifo.push_back(rsp.addr);
        m_fetched++;
      end
    end
    if (req && gnt) begin
      mq.push_back('{addr: issue_pc, due: cyc + $urandom_range(lat_hi, lat_lo), stale: 1'b0});
      issue_pc = issue_pc + 12'd1;
    end
    if (redir) begin
      foreach (mq[i]) mq[i].stale = 1'b1;
      mfifo.delete();
      issue_pc = tgt;
    end
    flush_exp = redir;
    if (run && hlt) halted = 1'b1;
    booting = 1'b0;
    cyc++;
    @(negedge clock);
  endtask

  initial begin
    bit found;
`ifdef FETCH_PERF_EN
    logic [15:0] snap;
`endif
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0; bus.instr_ready = 1'b0;
    bus.br_taken = 1'b0; bus.br_target = '0; bus.halt = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    check("rst_mem_req", 32'(bus.mem_req), 32'(0));
    check("rst_mem_addr", 32'(bus.mem_addr), 32'(12'o4000));
    check("rst_instr_valid", 32'(bus.instr_valid), 32'(0));
    check("rst_instr", 32'(bus.instr), 32'(0));
    check("rst_pc", 32'(bus.pc), 32'(0));
    check("rst_flush", 32'(bus.flush), 32'(0));
    @(negedge clock);
    rst_l = 1'b1;

    // Sequential fetch from reset with a 1-cycle memory.
    repeat (10) cycle(1'b1, 1'b1, 1'b0, 12'o0, 1'b0, 1'b1);

    // Decoder stalls: buffer fills, requests stop, then drains in order.
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (mfifo.size() == Depth) found = 1'b1;
      else cycle(1'b1, 1'b0, 1'b0, 12'o0, 1'b0, 1'b1);
    end
    check("fill_reached", 32'(found), 32'(1));
`ifdef FETCH_PERF_EN
    snap = perf_stall;
`endif
    repeat (10) cycle(1'b1, 1'b0, 1'b0, 12'o0, 1'b0, 1'b1);
`ifdef FETCH_PERF_EN
    check("perf_stall_10", 32'(perf_stall - snap), 32'(10));
`endif
    repeat (8) cycle(1'b1, 1'b1, 1'b0, 12'o0, 1'b0, 1'b1);

    // Redirect with two reads in flight: both are dropped.
    lat_lo = 3; lat_hi = 3;
    repeat (4) cycle(1'b0, 1'b1, 1'b0, 12'o0, 1'b0, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (mq.size() == 2) found = 1'b1;
      else cycle(1'b1, 1'b1, 1'b0, 12'o0, 1'b0, 1'b0);
    end
    check("two_outstanding", 32'(found), 32'(1));
`ifdef FETCH_PERF_EN
    snap = perf_dropped;
`endif
    cycle(1'b0, 1'b1, 1'b1, 12'o2050, 1'b0, 1'b0);
    lat_lo = 1; lat_hi = 1;
    repeat (12) cycle(1'b1, 1'b1, 1'b0, 12'o0, 1'b0, 1'b1);
`ifdef FETCH_PERF_EN
    check("perf_dropped_2", 32'(perf_dropped - snap), 32'(2));
`endif

    // Address wrap 7777 -> 0000.
    cycle(1'b0, 1'b1, 1'b1, 12'o7776, 1'b0, 1'b1);
    repeat (12) cycle(1'b1, 1'b1, 1'b0, 12'o0, 1'b0, 1'b1);

    // Random traffic with redirects.
    lat_lo = 1; lat_hi = 3;
    repeat (400) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0,
            12'($urandom), 1'b0, $urandom_range(0, 4) != 0);
    end

    // Halt with one read outstanding; branches ignored afterwards.
    repeat (10) cycle(1'b0, 1'b1, 1'b0, 12'o0, 1'b0, 1'b1);
    check("drained_before_halt", 32'(mq.size() + mfifo.size()), 32'(0));
    lat_lo = 2; lat_hi = 2;
    cycle(1'b1, 1'b1, 1'b0, 12'o0, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 12'o1234, 1'b1, 1'b1);
    repeat (8) cycle(1'b1, 1'b1, 1'b1, 12'o1234, 1'b0, 1'b1);

`ifdef FETCH_PERF_EN
    check("perf_fetched", 32'(perf_fetched), 32'(16'(m_fetched)));
    check("perf_dropped", 32'(perf_dropped), 32'(16'(m_dropped)));
    check("perf_stall", 32'(perf_stall), 32'(16'(m_stall)));
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
